counter_scheduler: RTL
======================

# counter_scheduler

Time-shares one 8-bit up-counter (clear/enable/count interface) among NREQ requesters that each need an exclusive timed window of a programmable number of cycles. Sits beside the shared counter: drives its reset and enable, watches its output, and issues grant/done handshakes to requesters in round-robin order. Each requester gets a window of exactly len counter increments.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: counter width; must equal the shared counter's output width.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until done or to abort.
- len  input  NREQ*WIDTH  packed window lengths; requester i uses len[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant to the current owner.
- done  output  NREQ  one-cycle completion pulse to the owner.
- busy  output  1  high in any state other than IDLE.
- cnt_reset  output  1  clear request to the shared counter.
- cnt_enable  output  1  count enable to the shared counter.
- cnt_value  input  WIDTH  shared counter output.

## Operation
- Shared counter behaviour (decided): at each rising edge, if cnt_reset then 0, else if cnt_enable then +1 mod 2^WIDTH.
- States: IDLE, CLEAR, RUN, DONE. Outputs are Moore, decoded from state and owner.
- IDLE: gnt=0, cnt_enable=0. If any req bit is high, pick owner by round robin; latch owner and its len (len_q); go to CLEAR.
- Round robin: search starts at ptr+1 mod NREQ and wraps. ptr updates to the new owner at the IDLE->CLEAR transition. Reset value is ptr=NREQ-1, so requester 0 wins first.
- CLEAR: cnt_reset=1, cnt_enable=0. If len_q==0, go to DONE; otherwise go to RUN.
- RUN: cnt_enable=1. When cnt_value==len_q-1, go to DONE; the counter ends at len_q. RUN lasts exactly len_q cycles. len_q=2^WIDTH-1 is legal; the counter never wraps inside a window.
- DONE: cnt_enable=0, done[owner]=1 for exactly one cycle; go to IDLE.
- gnt[owner]=1 in CLEAR, RUN and DONE. busy=1 in the same states.
- Abort: if req[owner] is low in CLEAR or RUN, go to IDLE next cycle with no done pulse and cnt_enable low from that cycle. ptr keeps the aborted owner. The counter holds its partial value.
- len changes after latching are ignored until the next arbitration.
- Requests from non-owners are queued only by remaining asserted; no request storage.
- req deasserting in DONE has no effect; done still pulses.

## Timing
- Reset: state=IDLE, ptr=NREQ-1, len_q=0, owner=0. gnt, done, busy and cnt_enable are 0. cnt_reset is 1 while reset is high (cnt_reset = reset | state==CLEAR), so the counter clears too.
- Reset mid-window wins over everything: next cycle is IDLE with no done pulse.
- A req seen in IDLE at cycle t gives:
  - CLEAR at t+1
  - RUN at t+2 .. t+1+len
  - DONE at t+2+len
  - IDLE at t+3+len
- Per-window occupancy is len+3 cycles, including one mandatory IDLE cycle between windows, even when requests are back-to-back.
- len=0: CLEAR at t+1, DONE at t+2.
- Simultaneous requests are resolved only in IDLE. There is no preemption.

## Test plan
- Single requester: req[0]=1, len0=5, hold → gnt[0] high 7 cycles, cnt_enable high exactly 5 cycles, cnt_value=5 at done[0], done pulse 1 cycle at t+7.
- Contention: req=4'b1111, all len=2, held until each done → grant order 0,1,2,3,0. Each window is 5 cycles and gnt is never multi-hot.
- Rotation: after req[2] is served, assert req[1] and req[3] together → 3 granted before 1.
- Zero length: req[1]=1, len1=0 → CLEAR then DONE, cnt_enable never high, cnt_value=0 at done[1].
- Abort: len0=10, drop req[0] on the 4th RUN cycle → next cycle IDLE, no done, cnt_value=4 held. A pending req[1] is granted next.
- Reset mid-RUN: len0=200, assert reset for 1 cycle at RUN cycle 50 → all outputs 0, cnt_value=0. A following req=4'b0011 grants 0 first.

Source files
------------

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of one up-counter among NREQ requesters
module counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_reset,
    output logic                  cnt_enable,
    input  logic [WIDTH-1:0]      cnt_value
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    ptr, owner, pick, cand;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_a [NREQ];
    logic [NREQ-1:0]  owner_oh;
    logic             found;

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_a[g] = len[g*WIDTH +: WIDTH];
    end

    assign owner_oh = NREQ'(1) << owner;

    // round-robin search starting just after the previous winner, wrapping once
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // state register plus owner/length latch taken at arbitration
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= IW'(NREQ - 1);
            owner <= '0;
            len_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                ptr   <= pick;
                owner <= pick;
                len_q <= len_a[pick];
            end
        end
    end

    // next state: an owner dropping req in CLEAR/RUN aborts without a done pulse
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = found ? CLEAR : IDLE;
            CLEAR:   state_nx = !req[owner] ? IDLE : (len_q == '0 ? DONE : RUN);
            RUN:     state_nx = !req[owner] ? IDLE : (cnt_value == len_q - 1'b1 ? DONE : RUN);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs; the counter is also cleared while reset is held
    always_comb begin
        busy       = state != IDLE;
        gnt        = busy ? owner_oh : '0;
        done       = state == DONE ? owner_oh : '0;
        cnt_reset  = reset || state == CLEAR;
        cnt_enable = state == RUN;
    end
endmodule
